// File: rtl/decoder2to4_hold_if.sv
// Code/valid link from the 4-to-2 priority encoder into the hold decoder,
// plus the decoder's held one-hot lines and status.
interface decoder2to4_hold_if #(
  parameter int CNT_W = 8
);
  logic             v;
  logic             c1;
  logic             c0;
  logic             y0;
  logic             y1;
  logic             y2;
  logic             y3;
  logic             busy;
  logic             overrun;
  logic [CNT_W-1:0] ev_count;

  modport master (
    output v, c1, c0,
    input  y0, y1, y2, y3, busy, overrun, ev_count
  );

  modport slave (
    input  v, c1, c0,
    output y0, y1, y2, y3, busy, overrun, ev_count
  );
endinterface

// File: rtl/decoder2to4_hold.sv
// Registered 2-to-4 decoder that pulse-stretches the decoded line for
// HOLD_CYCLES after the last valid code, counting events and flagging overruns.
module decoder2to4_hold #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  decoder2to4_hold_if.slave     bus
);
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [3:0]       RELOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] EV_MAX = {CNT_W{1'b1}};

  state_t           r_state, w_nxt_state;
  logic [3:0]       r_cnt, w_nxt_cnt;
  logic [1:0]       r_code, w_nxt_code;
  logic [3:0]       r_y, w_nxt_y;
  logic             r_ovr, w_nxt_ovr;
  logic [CNT_W-1:0] r_ev, w_nxt_ev;
  logic             w_evt;
  logic [1:0]       w_code;

  assign w_code = {bus.c1, bus.c0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_code  <= '0;
      r_y     <= '0;
      r_ovr   <= 1'b0;
      r_ev    <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_code  <= w_nxt_code;
      r_y     <= w_nxt_y;
      r_ovr   <= w_nxt_ovr;
      r_ev    <= w_nxt_ev;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_code  = r_code;
    w_nxt_y     = r_y;
    w_nxt_ovr   = 1'b0;
    w_evt       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.v) begin
          w_nxt_code  = w_code;
          w_nxt_y     = 4'b0001 << w_code;
          w_nxt_cnt   = RELOAD;
          w_nxt_state = HOLD;
          w_evt       = 1'b1;
        end
      end
      HOLD: begin
        if (bus.v) begin
          // Same code just retriggers; a new code switches lines with no gap.
          w_nxt_cnt = RELOAD;
          if (w_code != r_code) begin
            w_nxt_code = w_code;
            w_nxt_y    = 4'b0001 << w_code;
            w_nxt_ovr  = 1'b1;
            w_evt      = 1'b1;
          end
        end else if (r_cnt != 4'd0) begin
          w_nxt_cnt = r_cnt - 4'd1;
        end else begin
          w_nxt_y     = '0;
          w_nxt_state = IDLE;
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_y     = '0;
      end
    endcase
    w_nxt_ev = (w_evt && r_ev != EV_MAX) ? r_ev + CNT_W'(1) : r_ev;
  end

  assign bus.y0       = r_y[0];
  assign bus.y1       = r_y[1];
  assign bus.y2       = r_y[2];
  assign bus.y3       = r_y[3];
  assign bus.busy     = (r_state == HOLD);
  assign bus.overrun  = r_ovr;
  assign bus.ev_count = r_ev;
endmodule

// File: doc/decoder2to4_hold.md
Name: decoder2to4_hold

Overview:
- Registered 2-to-4 decoder; the receiving end of the 4-to-2 priority encoder link.
- Accepts a 2-bit code plus valid flag from the encoder.
- Drives a one-hot output line and holds (pulse-stretches) it for a programmable number of cycles.
- Counts decode events and flags codes that change before the hold expires. Used to drive LEDs/indicators that need a stable, visible pulse.

Parameters:
- HOLD_CYCLES, 4: cycles a decoded line stays high after the last valid sample; legal range 1..15.
- CNT_W, 8: width of the event counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- v  input  1  code valid; the encoder's v output.
- c1  input  1  code MSB; the encoder's o1 output.
- c0  input  1  code LSB; the encoder's o2 output.
- y0  output  1  decoded line for code 00.
- y1  output  1  decoded line for code 01.
- y2  output  1  decoded line for code 10.
- y3  output  1  decoded line for code 11.
- busy  output  1  high while a line is being held.
- overrun  output  1  one-cycle pulse when the code changes during a hold.
- ev_count  output  CNT_W  saturating count of decode events.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, any time, including mid-hold): y0..y3=0, busy=0, overrun=0, ev_count=0, state=IDLE, hold counter=0, captured code=00. Outputs clear immediately, without waiting for a clock edge.
- All outputs are registered. No combinational path from inputs to outputs.
- Output invariant: y0..y3 is either all-zero or exactly one-hot. Its index always equals the captured code {c1,c0}.
- States: IDLE, HOLD. busy=1 exactly when state=HOLD.
- IDLE, v=0 at edge: no change.
- IDLE, v=1 at edge k:
  - Capture {c1,c0}.
  - Drive the matching y line high from edge k; latency is 1 cycle from the sampled v.
  - Load the counter with HOLD_CYCLES-1.
  - Go to HOLD.
  - Increment ev_count.
- HOLD, v=1, same code: retrigger. Reload the counter with HOLD_CYCLES-1. No ev_count increment and no overrun. A continuously held v with a constant code therefore counts once.
- HOLD, v=1, different code:
  - Switch the one-hot output to the new index in the same edge. There is no all-zero gap cycle.
  - Reload the counter.
  - Increment ev_count.
  - Pulse overrun high for exactly one cycle.
- HOLD, v=0, counter>0: decrement the counter.
- HOLD, v=0, counter=0: clear y0..y3 and go to IDLE.
- Net hold timing: a line is high for exactly HOLD_CYCLES clock periods after the last edge at which v=1. HOLD_CYCLES=1 gives a single-cycle pulse.
- A new v=1 arriving on the same edge the hold would expire counts as a retrigger or a code change, not an expiry. There is no drop-out cycle.
- ev_count saturates at all-ones and never wraps.
- overrun defaults to 0 every cycle unless set by the code-change rule.
- c1/c0 are ignored whenever v=0.

Test Plan:
- Reset, then idle with v=0 for 10 cycles -> y0..y3=0000, busy=0, ev_count=0.
- HOLD_CYCLES=4; v=1 with code 10 for 1 cycle at edge k -> y2=1 and busy=1 during edges k..k+3; y2=0 and busy=0 after edge k+4; ev_count=1.
- v=1 with code 01 for 6 consecutive cycles -> y1 high continuously until 4 cycles after the last v; ev_count increments by exactly 1; overrun never asserts.
- Code 00, then code 11 two cycles later during the hold:
  - output goes 0001 -> 1000 with no zero cycle;
  - overrun high for exactly 1 cycle;
  - ev_count +2;
  - the hold runs 4 cycles from the 11 sample.
- Drive the exhaustive encoder sequence 0000 -> 0001 -> 0011 -> 0111 -> 1111 through the encoder into this block, at 20-cycle spacing -> y0, y1, y2, y3 each pulse once in order; ev_count=4.
- Assert rst_n=0 two cycles into a hold -> all outputs 0 immediately, before the next edge. After release, v=0 keeps IDLE; ev_count=0.
- CNT_W=2: generate 5 distinct-code events -> ev_count stops at 3 and does not wrap.
